// File: rtl/money_pkg.sv
// rtl/money_pkg.sv - shared state encoding, default rates and class indices for money_accumulator
package money_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        PAYOUT = 2'd2,
        CLEAR  = 2'd3
    } state_e;

    localparam int RATE_250ML  = 1;
    localparam int RATE_500ML  = 2;
    localparam int RATE_1250ML = 3;

    localparam int CLS_250ML  = 0;
    localparam int CLS_500ML  = 1;
    localparam int CLS_1250ML = 2;

endpackage

// File: rtl/bottle_class_counter.sv
// rtl/bottle_class_counter.sv - saturating per-class bottle counter with sticky overflow flag
module bottle_class_counter #(
    parameter int CNT_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] count_o,
    output logic             sat_o
);

    logic [CNT_W-1:0] cnt_q;
    logic             sat_q;

    // sat flags a bottle that arrived while the count was already pinned at max
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            sat_q <= 1'b0;
        end else if (clr_i) begin
            cnt_q <= '0;
            sat_q <= 1'b0;
        end else if (inc_i) begin
            if (&cnt_q) begin
                sat_q <= 1'b1;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign count_o = cnt_q;
    assign sat_o   = sat_q;

endmodule

// File: rtl/money_accumulator.sv
// rtl/money_accumulator.sv - per-class bottle counting and serial credit MAC; MONEY_AUDIT_EN adds audit counters
module money_accumulator
    import money_pkg::*;
#(
    parameter int NUM_CLASSES = 3,
    parameter int CNT_W       = 12,
    parameter int RATE_W      = 4,
    parameter int MONEY_W     = 16,
    localparam int CLS_W      = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          bottle_valid,
    input  logic [CLS_W-1:0]              bottle_class,
    output logic                          bottle_ready,
    input  logic [NUM_CLASSES*RATE_W-1:0] rate_table,
    input  logic                          payout_req,
    output logic                          money_valid,
    input  logic                          money_ready,
    output logic [MONEY_W-1:0]            money_out,
    output logic                          money_sat,
`ifdef MONEY_AUDIT_EN
    output logic [31:0]                   audit_total,
    output logic [15:0]                   audit_payouts,
`endif
    output logic [NUM_CLASSES*CNT_W-1:0]  class_count
);

    localparam int PROD_W = CNT_W + RATE_W;
    localparam int SUM_W  = ((MONEY_W > PROD_W) ? MONEY_W : PROD_W) + 1;
    localparam logic [CLS_W-1:0] LAST_IDX = CLS_W'(NUM_CLASSES - 1);

    state_e               state_q, state_d;
    logic [CLS_W-1:0]     idx_q, idx_d;
    logic [MONEY_W-1:0]   acc_q, acc_d;
    logic                 csat_q, csat_d;
    logic                 valid_q, valid_d;

    logic [CNT_W-1:0]     cnt      [NUM_CLASSES];
    logic [RATE_W-1:0]    rate     [NUM_CLASSES];
    logic [NUM_CLASSES-1:0] cnt_sat;
    logic [PROD_W-1:0]    prod;
    logic [SUM_W-1:0]     sum;

    for (genvar gi = 0; gi < NUM_CLASSES; gi++) begin : g_cls
        localparam logic [CLS_W-1:0] ID = CLS_W'(gi);

        assign rate[gi] = rate_table[gi*RATE_W +: RATE_W];
        assign class_count[gi*CNT_W +: CNT_W] = cnt[gi];

        // out-of-range class indices match no instance and vanish silently
        bottle_class_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk    (clk),
            .rst_n  (rst_n),
            .inc_i  (bottle_valid && (state_q == IDLE) && (bottle_class == ID)),
            .clr_i  (state_q == CLEAR),
            .count_o(cnt[gi]),
            .sat_o  (cnt_sat[gi])
        );
    end

    assign prod = PROD_W'(cnt[idx_q]) * PROD_W'(rate[idx_q]);
    assign sum  = SUM_W'(acc_q) + SUM_W'(prod);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        csat_d  = csat_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: begin
                if (payout_req) begin
                    state_d = CALC;
                    idx_d   = '0;
                    acc_d   = '0;
                end
            end
            CALC: begin
                if (|sum[SUM_W-1:MONEY_W]) begin
                    acc_d  = '1;
                    csat_d = 1'b1;
                end else begin
                    acc_d = sum[MONEY_W-1:0];
                end
                if (idx_q == LAST_IDX) begin
                    state_d = PAYOUT;
                    valid_d = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            PAYOUT: begin
                if (money_ready) begin
                    state_d = CLEAR;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
                acc_d   = '0;
                csat_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            acc_q   <= '0;
            csat_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            csat_q  <= csat_d;
            valid_q <= valid_d;
        end
    end

`ifdef MONEY_AUDIT_EN
    logic [31:0] aud_total_q;
    logic [15:0] aud_pay_q;
    logic [32:0] aud_sum;

    assign aud_sum = {1'b0, aud_total_q} + 33'(acc_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aud_total_q <= '0;
            aud_pay_q   <= '0;
        end else if (valid_q && money_ready) begin
            aud_total_q <= aud_sum[32] ? '1 : aud_sum[31:0];
            aud_pay_q   <= aud_pay_q + 1'b1;
        end
    end

    assign audit_total   = aud_total_q;
    assign audit_payouts = aud_pay_q;
`endif

    assign bottle_ready = (state_q == IDLE);
    assign money_valid  = valid_q;
    assign money_out    = acc_q;
    assign money_sat    = csat_q | (|cnt_sat);

endmodule

// File: tb/tb_money_accumulator.sv
// tb/tb_money_accumulator.sv - randomized self-checking bench for money_accumulator against a count/credit model
module tb_money_accumulator;

    localparam int NC   = 3;
    localparam int CW   = 5;
    localparam int RW   = 4;
    localparam int MW   = 9;
    localparam int CMAX = (1 << CW) - 1;
    localparam int MMAX = (1 << MW) - 1;

    logic              clk;
    logic              rst_n;
    logic              bottle_valid;
    logic [1:0]        bottle_class;
    logic              bottle_ready;
    logic [NC*RW-1:0]  rate_table;
    logic              payout_req;
    logic              money_valid;
    logic              money_ready;
    logic [MW-1:0]     money_out;
    logic              money_sat;
    logic [NC*CW-1:0]  class_count;
`ifdef MONEY_AUDIT_EN
    logic [31:0]       audit_total;
    logic [15:0]       audit_payouts;
`endif

    money_accumulator #(
        .NUM_CLASSES(NC),
        .CNT_W      (CW),
        .RATE_W     (RW),
        .MONEY_W    (MW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bottle_valid (bottle_valid),
        .bottle_class (bottle_class),
        .bottle_ready (bottle_ready),
        .rate_table   (rate_table),
        .payout_req   (payout_req),
        .money_valid  (money_valid),
        .money_ready  (money_ready),
        .money_out    (money_out),
        .money_sat    (money_sat),
`ifdef MONEY_AUDIT_EN
        .audit_total  (audit_total),
        .audit_payouts(audit_payouts),
`endif
        .class_count  (class_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int     n_tests;
    int     n_fail;
    int     ref_cnt [NC];
    bit     ref_sat;
    longint aud_total;
    int     aud_pay;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_bottle(input int cls);
        if (cls >= 0 && cls < NC) begin
            if (ref_cnt[cls] == CMAX) ref_sat = 1'b1;
            else ref_cnt[cls]++;
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NC; i++) ref_cnt[i] = 0;
        ref_sat = 1'b0;
    endtask

    task automatic put_bottle(input int cls);
        bottle_valid = 1'b1;
        bottle_class = 2'(cls);
        tick();
        bottle_valid = 1'b0;
        model_bottle(cls);
    endtask

    task automatic check_counts(input string tag);
        for (int i = 0; i < NC; i++) chk(tag, longint'(class_count[i*CW +: CW]), ref_cnt[i]);
    endtask

    task automatic check_audit(input string tag);
`ifdef MONEY_AUDIT_EN
        chk({tag, "_audit_total"}, audit_total, aud_total);
        chk({tag, "_audit_payouts"}, audit_payouts, aud_pay);
`endif
    endtask

    task automatic payout(input int r0, input int r1, input int r2, input int hold, input int same_cls);
        int     lat;
        longint sum;
        longint exp_m;
        bit     exp_s;
        rate_table = {4'(r2), 4'(r1), 4'(r0)};
        payout_req = 1'b1;
        if (same_cls >= 0) begin
            bottle_valid = 1'b1;
            bottle_class = 2'(same_cls);
            model_bottle(same_cls);
        end
        tick();
        payout_req   = 1'b0;
        bottle_valid = 1'b0;
        chk("calc_bottle_ready", bottle_ready, 0);
        lat = 1;
        while (!money_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk("latency", lat, NC + 1);
        sum   = longint'(ref_cnt[0]) * r0 + longint'(ref_cnt[1]) * r1 + longint'(ref_cnt[2]) * r2;
        exp_m = (sum > MMAX) ? MMAX : sum;
        exp_s = ref_sat || (sum > MMAX);
        chk("money_out", money_out, exp_m);
        chk("money_sat", money_sat, exp_s);
        for (int h = 0; h < hold; h++) begin
            bottle_valid = 1'($urandom_range(0, 1));
            bottle_class = 2'($urandom_range(0, 3));
            payout_req   = 1'($urandom_range(0, 1));
            tick();
            chk("hold_money_out", money_out, exp_m);
            chk("hold_valid", money_valid, 1);
            chk("hold_bottle_ready", bottle_ready, 0);
        end
        bottle_valid = 1'b0;
        payout_req   = 1'b0;
        check_counts("hold_counts");
        money_ready = 1'b1;
        tick();
        money_ready = 1'b0;
        chk("clear_valid", money_valid, 0);
        aud_total = aud_total + exp_m;
        if (aud_total > 64'hFFFF_FFFF) aud_total = 64'hFFFF_FFFF;
        aud_pay = (aud_pay + 1) & 16'hFFFF;
        tick();
        model_clear();
        check_counts("cleared_counts");
        chk("cleared_money_out", money_out, 0);
        chk("cleared_money_sat", money_sat, 0);
        chk("idle_bottle_ready", bottle_ready, 1);
        check_audit("post_handshake");
    endtask

    initial begin
        n_tests      = 0;
        n_fail       = 0;
        aud_total    = 0;
        aud_pay      = 0;
        model_clear();
        rst_n        = 1'b0;
        bottle_valid = 1'b0;
        bottle_class = '0;
        rate_table   = '0;
        payout_req   = 1'b0;
        money_ready  = 1'b0;
        #12 rst_n = 1'b1;
        tick();

        chk("rst_bottle_ready", bottle_ready, 1);
        chk("rst_money_valid", money_valid, 0);
        chk("rst_money_out", money_out, 0);
        chk("rst_money_sat", money_sat, 0);
        check_counts("rst_counts");
        check_audit("rst");

        for (int i = 0; i < 5; i++) put_bottle(0);
        put_bottle(3);
        for (int i = 0; i < 4; i++) put_bottle(1);
        for (int i = 0; i < 2; i++) put_bottle(2);
        check_counts("basic_counts");
        chk("basic_expect_19", longint'(ref_cnt[0]) * 1 + ref_cnt[1] * 2 + ref_cnt[2] * 3, 19);
        payout(1, 2, 3, 10, -1);

        payout(1, 2, 3, 0, -1);

        for (int i = 0; i < 40; i++) put_bottle(1);
        check_counts("cnt_sat_counts");
        payout(1, 2, 3, 2, -1);

        for (int c = 0; c < NC; c++)
            for (int i = 0; i < CMAX; i++) put_bottle(c);
        payout(15, 15, 15, 1, -1);

        payout(1, 2, 3, 0, 2);

        for (int t = 0; t < 8; t++) begin
            int n;
            n = $urandom_range(0, 45);
            for (int i = 0; i < n; i++) begin
                put_bottle(int'($urandom_range(0, 3)));
                if ($urandom_range(0, 3) == 0) tick();
            end
            check_counts("rand_counts");
            payout(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 15)), int'($urandom_range(0, 4)),
                   int'($urandom_range(0, 4)) - 1);
        end

        for (int i = 0; i < 3; i++) put_bottle(0);
        rate_table = {4'd3, 4'd2, 4'd1};
        payout_req = 1'b1;
        tick();
        payout_req = 1'b0;
        for (int i = 0; i < 20 && !money_valid; i++) tick();
        chk("pre_reset_valid", money_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        model_clear();
        aud_total = 0;
        aud_pay   = 0;
        chk("async_rst_valid", money_valid, 0);
        chk("async_rst_bottle_ready", bottle_ready, 1);
        chk("async_rst_money_out", money_out, 0);
        check_counts("async_rst_counts");
        check_audit("async_rst");
        #3 rst_n = 1'b1;
        tick();
        put_bottle(1);
        check_counts("post_rst_counts");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
